// File: rtl/mem_arbiter.sv
// Two-to-one IFU/LSU arbiter for a single valid/ready memory port; one transaction in flight.
// Grant is decided one cycle after the request. Request and response data pass through combinationally.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   input  logic [ADDR_W-1:0]   ifu_req_addr,
   output logic                ifu_req_ready,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_resp_rdata,
   output logic                ifu_resp_err,
   input  logic                ifu_resp_ready,
   input  logic                lsu_req_valid,
   input  logic [ADDR_W-1:0]   lsu_req_addr,
   input  logic                lsu_req_wen,
   input  logic [DATA_W-1:0]   lsu_req_wdata,
   input  logic [DATA_W/8-1:0] lsu_req_wmask,
   output logic                lsu_req_ready,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_resp_rdata,
   output logic                lsu_resp_err,
   input  logic                lsu_resp_ready,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wmask,
   input  logic                mem_resp_valid,
   output logic                mem_resp_ready,
   input  logic [DATA_W-1:0]   mem_resp_rdata,
   input  logic                mem_resp_err
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

   state_t state, state_nxt;
   owner_t owner, owner_nxt;
   owner_t last_owner, last_nxt;
   logic   wr_q, wr_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= OWN_IFU;
         last_owner <= OWN_LSU;
         wr_q       <= 1'b0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_nxt;
         wr_q       <= wr_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_nxt       = last_owner;
      wr_nxt         = wr_q;
      ifu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      ifu_resp_rdata = '0;
      ifu_resp_err   = 1'b0;
      lsu_req_ready  = 1'b0;
      lsu_resp_valid = 1'b0;
      lsu_resp_rdata = '0;
      lsu_resp_err   = 1'b0;
      mem_req_valid  = 1'b0;
      mem_req_addr   = '0;
      mem_req_wen    = 1'b0;
      mem_req_wdata  = '0;
      mem_req_wmask  = '0;
      mem_resp_ready = 1'b0;

      case (state)
         IDLE: begin
            // On a tie the unit that was not served last wins.
            if (ifu_req_valid && lsu_req_valid) begin
               owner_nxt = (last_owner == OWN_LSU) ? OWN_IFU : OWN_LSU;
               state_nxt = REQ;
            end else if (ifu_req_valid) begin
               owner_nxt = OWN_IFU;
               state_nxt = REQ;
            end else if (lsu_req_valid) begin
               owner_nxt = OWN_LSU;
               state_nxt = REQ;
            end
         end

         REQ: begin
            if (owner == OWN_IFU) begin
               mem_req_valid = ifu_req_valid;
               mem_req_addr  = ifu_req_addr;
               ifu_req_ready = mem_req_ready;
            end else begin
               mem_req_valid = lsu_req_valid;
               mem_req_addr  = lsu_req_addr;
               mem_req_wen   = lsu_req_wen;
               mem_req_wdata = lsu_req_wdata;
               mem_req_wmask = lsu_req_wmask;
               lsu_req_ready = mem_req_ready;
            end
            if (mem_req_valid && mem_req_ready) begin
               state_nxt = RESP;
               last_nxt  = owner;
               wr_nxt    = (owner == OWN_LSU) && lsu_req_wen;
            end
         end

         RESP: begin
            if (owner == OWN_IFU) begin
               mem_resp_ready = ifu_resp_ready;
               ifu_resp_valid = mem_resp_valid;
               ifu_resp_rdata = mem_resp_rdata;
               ifu_resp_err   = mem_resp_err;
            end else begin
               mem_resp_ready = lsu_resp_ready;
               lsu_resp_valid = mem_resp_valid;
               // Write acknowledgements carry no data back to the LSU.
               lsu_resp_rdata = wr_q ? '0 : mem_resp_rdata;
               lsu_resp_err   = mem_resp_err;
            end
            if (mem_resp_valid && mem_resp_ready) state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both requesters and the memory slave,
// queuing each expected transaction and retiring it when the owner's response completes.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err, ifu_resp_ready;
   logic [31:0] ifu_req_addr, ifu_resp_rdata;
   logic        lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_resp_ready;
   logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
   logic [3:0]  lsu_req_wmask;
   logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
   logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
   logic [3:0]  mem_req_wmask;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        lsu;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
      .ifu_resp_ready(ifu_resp_ready),
      .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
      .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
      .lsu_resp_ready(lsu_resp_ready),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
      .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
   );

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every handshake/response output and the response data must be idle.
   task automatic chk_quiet(input string tag);
      chk(tag, {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready,
                ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err,
                ifu_resp_rdata, lsu_resp_rdata}, '0);
   endtask

   // Called at the falling edge of an IDLE cycle with the request(s) already driven.
   task automatic run_txn(input int req_wait, input int resp_wait, input bit rearm);
      exp_t e, got;
      if (sb.size() == 0) begin
         chk("sb_underflow", 1, 0);
         return;
      end
      e = sb[0];
      #1;
      chk("idle_mem_req_valid", mem_req_valid, 1'b0);
      chk("idle_req_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
      for (int i = 0; i <= req_wait; i++) begin
         @(negedge clk);
         mem_req_ready = (i == req_wait);
         #1;
         chk("req_valid", mem_req_valid, 1'b1);
         chk("req_addr", mem_req_addr, e.addr);
         chk("req_wen", mem_req_wen, e.wen);
         chk("req_wmask", mem_req_wmask, e.wmask);
         if (e.lsu) chk("req_wdata", mem_req_wdata, e.wdata);
         chk("req_ready_owner_other",
             e.lsu ? {lsu_req_ready, ifu_req_ready} : {ifu_req_ready, lsu_req_ready},
             {(i == req_wait), 1'b0});
         chk("req_no_resp", {ifu_resp_valid, lsu_resp_valid, mem_resp_ready}, 3'b000);
      end
      @(negedge clk);
      mem_req_ready = 1'b0;
      if (!rearm) begin
         if (e.lsu) lsu_req_valid = 1'b0;
         else       ifu_req_valid = 1'b0;
      end
      mem_resp_valid = 1'b1;
      mem_resp_rdata = e.rdata;
      mem_resp_err   = e.err;
      for (int i = 0; i <= resp_wait; i++) begin
         if (i > 0) @(negedge clk);
         if (e.lsu) lsu_resp_ready = (i == resp_wait);
         else       ifu_resp_ready = (i == resp_wait);
         #1;
         chk("resp_valid_owner_other",
             e.lsu ? {lsu_resp_valid, ifu_resp_valid} : {ifu_resp_valid, lsu_resp_valid}, 2'b10);
         chk("resp_mem_ready", mem_resp_ready, (i == resp_wait));
         chk("resp_no_req", {mem_req_valid, ifu_req_ready, lsu_req_ready}, 3'b000);
         if (i == resp_wait) begin
            got = sb.pop_front();
            chk("resp_rdata", e.lsu ? lsu_resp_rdata : ifu_resp_rdata, got.rdata);
            chk("resp_err", e.lsu ? lsu_resp_err : ifu_resp_err, got.err);
         end
      end
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      mem_resp_err   = 1'b0;
      ifu_resp_ready = 1'b0;
      lsu_resp_ready = 1'b0;
   endtask

   function automatic exp_t mk(input logic lsu, input logic [31:0] addr, input logic wen,
                               input logic [31:0] wdata, input logic [3:0] wmask,
                               input logic [31:0] rdata, input logic err);
      exp_t e;
      e.lsu = lsu; e.addr = addr; e.wen = wen; e.wdata = wdata;
      e.wmask = wmask; e.rdata = rdata; e.err = err;
      return e;
   endfunction

   initial begin
      rst = 1'b1;
      ifu_req_valid = 0; ifu_req_addr = '0; ifu_resp_ready = 0;
      lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0;
      lsu_req_wmask = '0; lsu_resp_ready = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0; mem_resp_err = 0;
      repeat (3) @(negedge clk);
      #1 chk_quiet("reset_outputs");
      @(negedge clk);
      rst = 1'b0;

      // IFU-only read, zero wait states
      @(negedge clk);
      ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
      sb.push_back(mk(0, 32'h8000_0000, 0, '0, 4'h0, 32'h0000_0413, 0));
      run_txn(0, 0, 0);
      #1 chk_quiet("ifu_only_back_idle");

      // LSU write
      @(negedge clk);
      lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
      lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF;
      sb.push_back(mk(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 32'h0, 0));
      run_txn(0, 0, 0);

      // Tie with both units holding requests: IFU, LSU, IFU
      ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100;
      lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 1;
      lsu_req_wdata = 32'hCAFE_F00D; lsu_req_wmask = 4'b0011;
      sb.push_back(mk(0, 32'h8000_0100, 0, '0, 4'h0, 32'h1111_1111, 0));
      sb.push_back(mk(1, 32'h8000_2000, 1, 32'hCAFE_F00D, 4'b0011, 32'h0, 0));
      sb.push_back(mk(0, 32'h8000_0100, 0, '0, 4'h0, 32'h2222_2222, 0));
      run_txn(0, 0, 1);
      run_txn(0, 0, 1);
      run_txn(0, 0, 0);

      // Backpressure on both phases; IFU also waiting, LSU owns (IFU served last)
      ifu_req_valid = 1; ifu_req_addr = 32'h0000_0000;
      sb.push_back(mk(1, 32'h8000_2000, 1, 32'hCAFE_F00D, 4'b0011, 32'h0, 0));
      run_txn(4, 3, 0);

      // Error response on the pending IFU read of address 0
      sb.push_back(mk(0, 32'h0000_0000, 0, '0, 4'h0, 32'hBAD0_BAD0, 1));
      run_txn(0, 0, 0);
      #1 chk_quiet("err_back_idle");

      // Reset while the slave holds a response for the LSU
      @(negedge clk);
      ifu_req_valid = 1; ifu_req_addr = 32'h8000_0200;
      lsu_req_valid = 1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 0;
      lsu_req_wdata = '0; lsu_req_wmask = 4'h0;
      @(negedge clk);
      mem_req_ready = 1;
      #1 chk("rst_case_lsu_granted", {lsu_req_ready, ifu_req_ready}, 2'b10);
      @(negedge clk);
      mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0055;
      #1 chk("rst_case_resp_held", {lsu_resp_valid, mem_resp_ready}, 2'b10);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1 chk_quiet("rst_mid_resp_outputs");
      mem_resp_valid = 0; mem_resp_rdata = '0;
      rst = 1'b0;
      sb.push_back(mk(0, 32'h8000_0200, 0, '0, 4'h0, 32'h6666_6666, 0));
      sb.push_back(mk(1, 32'h8000_3000, 0, '0, 4'h0, 32'h7777_7777, 0));
      run_txn(0, 0, 0);
      run_txn(0, 0, 0);
      #1 chk_quiet("final_idle");
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
